ntt_seq_engine: RTL and testbench

//  Sequential, parametrised N-point number-theoretic transform: X[i] = sum_j a[j]*w^(i*j) mod q.

---
 rtl/ntt_seq_engine.sv | 189 ++++++++++++++++++
 tb/tb_ntt_seq_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_engine.sv
// rtl/ntt_seq_engine.sv - sequential N-point NTT using one modular MAC
// Optional macro NTT_INVERSE_EN adds the inverse transform (w_inv stepping plus n_inv scale).
module ntt_seq_engine #(
  parameter int N  = 32,
  parameter int CW = 4,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [QW-1:0] q,
  input  logic [QW-1:0] w,
`ifdef NTT_INVERSE_EN
  input  logic          inv,
  input  logic [QW-1:0] w_inv,
  input  logic [QW-1:0] n_inv,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  typedef logic [AW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N - 1);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
`ifdef NTT_INVERSE_EN
    , SCALE
`endif
  } state_t;

  // Moduli below 2 collapse every residue to zero, which also avoids a divide by zero.
  function automatic logic [QW-1:0] modr(input logic [2*QW-1:0] x, input logic [QW-1:0] m);
    logic [2*QW-1:0] mm;
    mm = (2*QW)'(m);
    if (m < QW'(2)) return '0;
    return QW'(x % mm);
  endfunction

  state_t        state;
  idx_t          j;
  idx_t          i;
  logic [QW-1:0] qr;
  logic [QW-1:0] wstep;
  logic [QW-1:0] wi;
  logic [QW-1:0] tw;
  logic [QW-1:0] acc;
  logic [QW-1:0] coef_mem [N];
`ifdef NTT_INVERSE_EN
  logic          inv_r;
  logic [QW-1:0] ninv_r;
`endif

  logic          accept;
  logic [QW-1:0] q_eff;
  logic [QW-1:0] coef_in;
  logic [QW-1:0] tw_cur;
  logic [QW-1:0] acc_cur;
  logic [QW-1:0] term;
  logic [QW:0]   sum;
  logic [QW-1:0] acc_nxt;
  logic [QW-1:0] tw_nxt;
  logic [QW-1:0] wi_nxt;
  logic [QW-1:0] wstep_new;

  always_comb begin
    accept  = (state == LOAD) && in_valid && in_ready;
    // The first beat of a frame reduces against the modulus being latched alongside it.
    q_eff   = (j == '0) ? q : qr;
    coef_in = modr((2*QW)'(in_data), q_eff);
    tw_cur  = (j == '0) ? QW'(1) : tw;
    acc_cur = (j == '0) ? '0 : acc;
    term    = modr((2*QW)'(coef_mem[j]) * (2*QW)'(tw_cur), qr);
    sum     = {1'b0, acc_cur} + {1'b0, term};
    acc_nxt = (sum >= {1'b0, qr}) ? QW'(sum - {1'b0, qr}) : QW'(sum);
    tw_nxt  = modr((2*QW)'(tw_cur) * (2*QW)'(wi), qr);
    wi_nxt  = modr((2*QW)'(wi) * (2*QW)'(wstep), qr);
`ifdef NTT_INVERSE_EN
    wstep_new = inv ? modr((2*QW)'(w_inv), q) : modr((2*QW)'(w), q);
`else
    wstep_new = modr((2*QW)'(w), q);
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) coef_mem[j] <= coef_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      j         <= '0;
      i         <= '0;
      qr        <= '0;
      wstep     <= '0;
      wi        <= '0;
      tw        <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef NTT_INVERSE_EN
      inv_r     <= 1'b0;
      ninv_r    <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (j == '0) begin
              qr    <= q;
              wstep <= wstep_new;
              wi    <= QW'(1);
`ifdef NTT_INVERSE_EN
              inv_r  <= inv;
              ninv_r <= modr((2*QW)'(n_inv), q);
`endif
            end
            if (j == LAST_IDX) begin
              j        <= '0;
              i        <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= COMPUTE;
            end else begin
              j <= j + idx_t'(1);
            end
          end
        end
        COMPUTE: begin
          acc <= acc_nxt;
          tw  <= tw_nxt;
          if (j == LAST_IDX) begin
            j <= '0;
`ifdef NTT_INVERSE_EN
            if (inv_r) begin
              state <= SCALE;
            end else
`endif
            begin
              out_data  <= acc_nxt;
              out_valid <= 1'b1;
              out_last  <= (i == LAST_IDX);
              state     <= OUTPUT;
            end
          end else begin
            j <= j + idx_t'(1);
          end
        end
`ifdef NTT_INVERSE_EN
        SCALE: begin
          out_data  <= modr((2*QW)'(acc) * (2*QW)'(ninv_r), qr);
          out_valid <= 1'b1;
          out_last  <= (i == LAST_IDX);
          state     <= OUTPUT;
        end
`endif
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (i == LAST_IDX) begin
              i        <= '0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= LOAD;
            end else begin
              i     <= i + idx_t'(1);
              wi    <= wi_nxt;
              state <= COMPUTE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_seq_engine.sv
// tb/tb_ntt_seq_engine.sv - scoreboard bench for ntt_seq_engine (N=4 directed, N=32 random)
// Inverse-mode step is compiled only when NTT_INVERSE_EN is defined.
module tb_ntt_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] s_q, s_w, s_in_data, s_out_data;
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
  logic [7:0] b_q, b_w, b_out_data;
  logic [3:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
`ifdef NTT_INVERSE_EN
  logic       s_inv, b_inv;
  logic [7:0] s_w_inv, s_n_inv, b_w_inv, b_n_inv;
`endif

  ntt_seq_engine #(.N(4), .CW(8), .QW(8)) u_small (
    .clk(clk), .rst_n(rst_n), .q(s_q), .w(s_w),
`ifdef NTT_INVERSE_EN
    .inv(s_inv), .w_inv(s_w_inv), .n_inv(s_n_inv),
`endif
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy)
  );

  ntt_seq_engine #(.N(32), .CW(4), .QW(8)) u_big (
    .clk(clk), .rst_n(rst_n), .q(b_q), .w(b_w),
`ifdef NTT_INVERSE_EN
    .inv(b_inv), .w_inv(b_w_inv), .n_inv(b_n_inv),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  int frame[$];
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint powm(input longint b, input int e, input longint m);
    longint r = 1;
    longint x = b % m;
    int     k = e;
    while (k > 0) begin
      if (k[0]) r = (r * x) % m;
      x = (x * x) % m;
      k = k >> 1;
    end
    return r % m;
  endfunction

  function automatic int ntt_ref(input int a[$], input int m, input int root, input int idx);
    longint s = 0;
    if (m < 2) return 0;
    for (int jj = 0; jj < a.size(); jj++)
      s = (s + longint'(a[jj] % m) * powm(longint'(root), idx * jj, longint'(m))) % m;
    return int'(s);
  endfunction

  task automatic set4(input int a0, input int a1, input int a2, input int a3);
    frame = {};
    frame.push_back(a0); frame.push_back(a1); frame.push_back(a2); frame.push_back(a3);
  endtask

  task automatic push_fwd(input int m, input int root);
    for (int k = 0; k < frame.size(); k++) exp_q.push_back(ntt_ref(frame, m, root, k));
  endtask

  task automatic send_s();
    int cnt;
    for (int jj = 0; jj < frame.size(); jj++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(frame[jj]);
      cnt = 0;
      while (!s_in_ready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) check("in_ready_timeout", 32'(cnt), 0);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
  endtask

  task automatic recv_s(input int exp_lat, input int stall_beat, input int stall_len);
    int lat;
    int ev;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
      check("s_latency", 32'(lat), 32'(exp_lat));
      ev = exp_q.pop_front();
      check("s_out_data", 32'(s_out_data), 32'(ev));
      check("s_out_last", 32'(s_out_last), 32'(k == 3));
      check("s_in_ready_busy", 32'(s_in_ready), 0);
      if (k == stall_beat) begin
        s_out_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_valid", 32'(s_out_valid), 1);
          check("stall_data", 32'(s_out_data), 32'(ev));
          check("stall_busy", 32'(s_busy), 1);
        end
        s_out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("s_in_ready_after_last", 32'(s_in_ready), 1);
    check("s_busy_after_last", 32'(s_busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bexp[32];
    int cnt;
    int lat;
    int rdy_bad;
    rst_n = 1'b0;
    s_q = 8'd17; s_w = 8'd4; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    b_q = 8'd97; b_w = 8'd28; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef NTT_INVERSE_EN
    s_inv = 1'b0; s_w_inv = '0; s_n_inv = '0;
    b_inv = 1'b0; b_w_inv = '0; b_n_inv = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(s_out_valid), 0);
    check("rst_out_data", 32'(s_out_data), 0);
    check("rst_out_last", 32'(s_out_last), 0);
    check("rst_busy", 32'(s_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 32'(s_in_ready), 1);

    // Basic forward frame: [10,7,15,6], latency 4 per result.
    set4(1, 2, 3, 4); push_fwd(17, 4);
    send_s();
    recv_s(4, -1, 0);

    // Same frame with a 5-cycle stall on X1.
    set4(1, 2, 3, 4); push_fwd(17, 4);
    send_s();
    recv_s(4, 1, 5);

    // Coefficient above q is reduced on entry.
    set4(18, 2, 3, 4); push_fwd(17, 4);
    send_s();
    recv_s(4, -1, 0);

    // w above q is reduced when latched.
    s_w = 8'd21;
    set4(1, 2, 3, 4); push_fwd(17, 4);
    send_s();
    recv_s(4, -1, 0);
    s_w = 8'd4;

    // Async reset mid-compute, then a fresh frame.
    set4(1, 2, 3, 4);
    send_s();
    @(negedge clk);
    check("busy_mid_compute", 32'(s_busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(s_out_valid), 0);
    check("rst_mid_busy", 32'(s_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst2", 32'(s_in_ready), 1);
    set4(1, 1, 1, 1); push_fwd(17, 4);
    send_s();
    recv_s(4, -1, 0);

    // Degenerate modulus: all-zero results, full frame still emitted.
    s_q = 8'd1;
    set4(5, 6, 7, 8); push_fwd(1, 4);
    send_s();
    recv_s(4, -1, 0);
    s_q = 8'd17;

`ifdef NTT_INVERSE_EN
    s_inv = 1'b1; s_w_inv = 8'd13; s_n_inv = 8'd13;
    set4(10, 7, 15, 6);
    for (int k = 0; k < 4; k++) exp_q.push_back((ntt_ref(frame, 17, 13, k) * 13) % 17);
    send_s();
    recv_s(5, -1, 0);
    s_inv = 1'b0;
`endif

    // Large instance: random frames against the software model; second frame uses w >= q.
    for (int f = 0; f < 2; f++) begin
      b_w = (f == 0) ? 8'd28 : 8'd125;
      frame = {};
      for (int jj = 0; jj < 32; jj++) frame.push_back(int'($urandom_range(0, 15)));
      for (int k = 0; k < 32; k++) bexp[k] = ntt_ref(frame, 97, 28, k);
      for (int jj = 0; jj < 32; jj++) begin
        b_in_valid = 1'b1;
        b_in_data  = 4'(frame[jj]);
        cnt = 0;
        while (!b_in_ready && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) check("b_in_ready_timeout", 32'(cnt), 0);
        @(negedge clk);
      end
      b_in_valid = 1'b0;
      rdy_bad = 0;
      for (int k = 0; k < 32; k++) begin
        lat = 0;
        while (!b_out_valid && lat < 200) begin
          if (b_in_ready) rdy_bad++;
          @(negedge clk);
          lat++;
        end
        if (b_in_ready) rdy_bad++;
        check("b_latency", 32'(lat), 32);
        check("b_out_data", 32'(b_out_data), 32'(bexp[k]));
        check("b_out_last", 32'(b_out_last), 32'(k == 31));
        @(negedge clk);
      end
      check("b_in_ready_low_during_frame", 32'(rdy_bad), 0);
      check("b_in_ready_after_last", 32'(b_in_ready), 1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
